// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - debounce FSM state encoding
//   BLANK_DIGIT - 5-bit blank code understood by the seven-segment display
//   CNT_W       - width of the debounce scan counter (DBCOUNT <= 15)
//   KEYMAP      - hex code per key, indexed by {row, col}
//   low_row()   - lowest active row in a 4-bit hit vector
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [4:0] BLANK_DIGIT = 5'b10000;
  localparam int         CNT_W       = 4;

  // Index 15 is leftmost: row3 = 0 F E D, row2 = 7 8 9 C, row1 = 4 5 6 B, row0 = 1 2 3 A.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] low_row(input logic [3:0] hits);
    if (hits[0])      low_row = 2'd0;
    else if (hits[1]) low_row = 2'd1;
    else if (hits[2]) low_row = 2'd2;
    else              low_row = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: decoded-key output bundle of keypad_scan.
//   keyValid - one-cycle pulse per accepted press
//   keyCode  - hex code of the last accepted key
//   keyHeld  - accepted key down or being release-debounced
//   multiKey - more than one key seen in the last full scan
//   digits   - 4-digit shift buffer {d3,d2,d1,d0}, only with KEYPAD_SHIFT_EN
// master: the scanner (drives); slave: the consumer (reads).
interface keypad_if;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyHeld;
  logic       multiKey;
`ifdef KEYPAD_SHIFT_EN
  logic [19:0] digits;

  modport master (output keyValid, keyCode, keyHeld, multiKey, digits);
  modport slave  (input  keyValid, keyCode, keyHeld, multiKey, digits);
`else
  modport master (output keyValid, keyCode, keyHeld, multiKey);
  modport slave  (input  keyValid, keyCode, keyHeld, multiKey);
`endif
endinterface

// File: rtl/keypad_col_driver.sv
// keypad_col_driver: column scan timing for the 4x4 keypad.
//   clk, rst  - clock, synchronous active-high reset
//   row       - raw active-low row returns (asynchronous)
//   col       - active-low one-hot column drive
//   ci        - current column index
//   row_s     - row returns after a 2-flop synchronizer
//   samp      - strobe: sample row_s for column ci this cycle
//   scan_end  - strobe: the sample of column 3, closing a full scan
module keypad_col_driver #(
  parameter int SCWIDTH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [1:0] ci,
  output logic [3:0] row_s,
  output logic       samp,
  output logic       scan_end
);

  logic [SCWIDTH-1:0] dwell;
  logic [3:0]         row_m;

  // Dwell counter wraps naturally at 2^SCWIDTH; its terminal count is the sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
      ci    <= '0;
      row_m <= '1;
      row_s <= '1;
    end else begin
      dwell <= dwell + 1'b1;
      row_m <= row;
      row_s <= row_m;
      if (samp) ci <= ci + 2'd1;
    end
  end

  assign samp     = &dwell;
  assign scan_end = samp && (ci == 2'd3);
  assign col      = ~(4'b0001 << ci);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and hex decode.
//   clk, rst - clock, synchronous active-high reset
//   row      - raw active-low row returns
//   col      - active-low column drive
//   kp       - keypad_if.master: keyValid, keyCode, keyHeld, multiKey
//              (+ digits when KEYPAD_SHIFT_EN is defined)
// SCWIDTH sets the per-column dwell (2^SCWIDTH clocks); DBCOUNT is the number
// of consecutive matching full scans required to accept a press or a release.
// Optional feature macro: KEYPAD_SHIFT_EN adds a 4-digit shift buffer in the
// seven-segment display's 5-bit digit format.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCWIDTH = 15,
  parameter int DBCOUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  keypad_if.master   kp
);

  localparam logic [CNT_W-1:0] DBC = CNT_W'(DBCOUNT);

  logic [1:0] ci;
  logic [3:0] row_s, hits;
  logic       samp, scan_end;

  keypad_col_driver #(.SCWIDTH(SCWIDTH)) u_col (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .ci       (ci),
    .row_s    (row_s),
    .samp     (samp),
    .scan_end (scan_end)
  );

  // Scan accumulator: columns arrive in ascending order, so the first column
  // with any hit owns the key (lowest row within it); later hits only mark multi.
  logic       acc_found, acc_multi;
  logic [3:0] acc_code;
  logic       any_hit, two_hits, found_c, multi_c;
  logic [3:0] code_c;

  assign hits     = ~row_s;
  assign any_hit  = |hits;
  assign two_hits = |(hits & (hits - 4'd1));
  assign found_c  = acc_found | any_hit;
  assign code_c   = acc_found ? acc_code : KEYMAP[{low_row(hits), ci}];
  assign multi_c  = acc_multi | two_hits | (acc_found & any_hit);

  always_ff @(posedge clk) begin
    if (rst || (samp && scan_end)) begin
      acc_found <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= '0;
    end else if (samp) begin
      acc_found <= found_c;
      acc_multi <= multi_c;
      acc_code  <= code_c;
    end
  end

  // Debounce FSM, advanced only on scan_end with the completed scan result.
  state_t           state, st_nx;
  logic [3:0]       cand, cand_nx, new_code;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             accept;

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    st_nx    = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    accept   = 1'b0;
    new_code = cand;
    if (scan_end) begin
      case (state)
        IDLE: if (found_c) begin
          cand_nx  = code_c;
          new_code = code_c;
          cnt_nx   = CNT_W'(1);
          if (DBC == CNT_W'(1)) begin
            st_nx  = HELD;
            accept = 1'b1;
          end else begin
            st_nx  = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!found_c) begin
            st_nx = IDLE;
          end else if (code_c == cand) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == DBC) begin
              st_nx  = HELD;
              accept = 1'b1;
            end
          end else begin
            cand_nx = code_c;
            cnt_nx  = CNT_W'(1);
          end
        end
        // Any key while held keeps HELD: no auto-repeat, no roll-over.
        HELD: if (!found_c) begin
          cnt_nx = CNT_W'(1);
          st_nx  = (DBC == CNT_W'(1)) ? IDLE : RELEASE;
        end
        // A key reappearing during release is treated as the same press.
        RELEASE: begin
          if (found_c) begin
            st_nx = HELD;
          end else begin
            cnt_nx = cnt_inc;
            if (cnt_inc == DBC) st_nx = IDLE;
          end
        end
        default: st_nx = IDLE;
      endcase
    end
  end

  logic       kv, held, mk;
  logic [3:0] kc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      kv    <= 1'b0;
      kc    <= '0;
      held  <= 1'b0;
      mk    <= 1'b0;
    end else begin
      state <= st_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
      kv    <= accept;
      if (accept)   kc <= new_code;
      held  <= (st_nx == HELD) || (st_nx == RELEASE);
      if (scan_end) mk <= multi_c;
    end
  end

  assign kp.keyValid = kv;
  assign kp.keyCode  = kc;
  assign kp.keyHeld  = held;
  assign kp.multiKey = mk;

`ifdef KEYPAD_SHIFT_EN
  // kc is loaded on the same edge that raises kv, so it is current here.
  logic [19:0] digits_q;

  always_ff @(posedge clk) begin
    if (rst)     digits_q <= {4{BLANK_DIGIT}};
    else if (kv) digits_q <= {digits_q[14:0], 1'b0, kc};
  end

  assign kp.digits = digits_q;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan with
// SCWIDTH=2, DBCOUNT=3 (16-clock scans). A behavioural 4x4 matrix drives row
// from col and the set of pressed keys (bit r*4+c). Inputs change and outputs
// are sampled on the falling edge; each scan begins in column 0's first cycle.
module tb_keypad_scan;

  localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004, K4 = 16'h0010,
                          K5 = 16'h0020, K6 = 16'h0040, K8 = 16'h0200, KD = 16'h8000;
  localparam logic [19:0] ALL_BLANK = 20'b10000_10000_10000_10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col;
  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;

  keypad_if kp();

  keypad_scan #(.SCWIDTH(2), .DBCOUNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .row (row),
    .col (col),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  // One full scan with the given keys; pulses counts keyValid cycles up to and
  // including the first cycle of the next scan.
  task automatic do_scan(input logic [15:0] keys, output int pulses);
    pressed = keys;
    pulses  = 0;
    repeat (16) begin
      @(negedge clk);
      if (kp.keyValid === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col); end
    checks++;
    if ({kp.keyValid, kp.keyCode, kp.keyHeld, kp.multiKey} !== 7'd0) begin
      errors++; $display("FAIL reset_outs: got v%b c%h h%b m%b want all 0",
                         kp.keyValid, kp.keyCode, kp.keyHeld, kp.multiKey);
    end
    checks++;
`ifdef KEYPAD_SHIFT_EN
    if (kp.digits !== ALL_BLANK) begin errors++; $display("FAIL reset_digits: got %b want %b", kp.digits, ALL_BLANK); end
    checks++;
`endif
    rst = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 4 || j == 8 || j == 12) begin
        if (col !== ~(4'b0001 << (j / 4))) begin
          errors++; $display("FAIL reset_walk: clk %0d got %b want %b", j, col, ~(4'b0001 << (j / 4)));
        end
        checks++;
      end
    end
  endtask

  task automatic test_clean_press;
    int p, tot;
    tot = 0;
    for (int s = 0; s < 6; s++) begin
      do_scan(K6, p);
      tot += p;
      if (s == 1) begin
        if (tot != 0) begin errors++; $display("FAIL clean_early: got %0d pulses want 0", tot); end
        checks++;
      end
      if (s == 2) begin
        if (kp.keyValid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b want 1", kp.keyValid); end
        checks++;
        if (kp.keyCode !== 4'h6) begin errors++; $display("FAIL clean_code: got %h want 6", kp.keyCode); end
        checks++;
        if (kp.keyHeld !== 1'b1) begin errors++; $display("FAIL clean_held: got %b want 1", kp.keyHeld); end
        checks++;
      end
    end
    if (kp.multiKey !== 1'b0) begin errors++; $display("FAIL clean_multi: got %b want 0", kp.multiKey); end
    checks++;
    for (int s = 0; s < 3; s++) begin
      do_scan('0, p);
      tot += p;
      if (kp.keyHeld !== (s < 2)) begin errors++; $display("FAIL clean_release: scan %0d got %b want %b", s, kp.keyHeld, s < 2); end
      checks++;
    end
    if (tot != 1) begin errors++; $display("FAIL clean_pulses: got %0d want 1", tot); end
    checks++;
  endtask

  task automatic test_bounce;
    logic [15:0] seq1 [6];
    logic [15:0] seq2 [4];
    int p;
    seq1 = '{K5, K5, 16'h0, K5, K5, K5};
    seq2 = '{K5, K8, K8, K8};
    for (int s = 0; s < 6; s++) begin
      do_scan(seq1[s], p);
      if (p != ((s == 5) ? 1 : 0)) begin errors++; $display("FAIL bounce_pulse: scan %0d got %0d want %0d", s, p, (s == 5) ? 1 : 0); end
      checks++;
    end
    if (kp.keyCode !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h want 5", kp.keyCode); end
    checks++;
    repeat (3) do_scan('0, p);
    for (int s = 0; s < 4; s++) begin
      do_scan(seq2[s], p);
      if (p != ((s == 3) ? 1 : 0)) begin errors++; $display("FAIL restart_pulse: scan %0d got %0d want %0d", s, p, (s == 3) ? 1 : 0); end
      checks++;
    end
    if (kp.keyCode !== 4'h8) begin errors++; $display("FAIL restart_code: got %h want 8", kp.keyCode); end
    checks++;
    repeat (3) do_scan('0, p);
  endtask

  task automatic test_multi;
    int p, tot;
    for (int s = 0; s < 3; s++) begin
      do_scan(K1 | KD, p);
      if (s == 0) begin
        if (kp.multiKey !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b want 1", kp.multiKey); end
        checks++;
      end
    end
    if (p != 1 || kp.keyCode !== 4'h1) begin errors++; $display("FAIL multi_accept: got %0d pulses code %h want 1 pulse code 1", p, kp.keyCode); end
    checks++;
    tot = 0;
    repeat (2) begin do_scan(K1 | K2, p); tot += p; end
    if (tot != 0) begin errors++; $display("FAIL multi_second: got %0d pulses want 0", tot); end
    checks++;
    if (kp.keyHeld !== 1'b1 || kp.keyCode !== 4'h1) begin errors++; $display("FAIL multi_hold: got h%b c%h want h1 c1", kp.keyHeld, kp.keyCode); end
    checks++;
    do_scan('0, p);
    if (kp.multiKey !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b want 0", kp.multiKey); end
    checks++;
    repeat (2) do_scan('0, p);
    if (kp.keyHeld !== 1'b0) begin errors++; $display("FAIL multi_release: got %b want 0", kp.keyHeld); end
    checks++;
  endtask

  task automatic test_release_glitch;
    int p, tot;
    repeat (3) do_scan(K3, p);
    if (p != 1 || kp.keyCode !== 4'h3) begin errors++; $display("FAIL glitch_accept: got %0d pulses code %h want 1 pulse code 3", p, kp.keyCode); end
    checks++;
    tot = 0;
    do_scan('0, p); tot += p;
    do_scan(K3, p); tot += p;
    if (kp.keyHeld !== 1'b1) begin errors++; $display("FAIL glitch_held: got %b want 1", kp.keyHeld); end
    checks++;
    for (int s = 0; s < 3; s++) begin
      do_scan('0, p);
      tot += p;
      if (kp.keyHeld !== (s < 2)) begin errors++; $display("FAIL glitch_release: scan %0d got %b want %b", s, kp.keyHeld, s < 2); end
      checks++;
    end
    if (tot != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", tot); end
    checks++;
  endtask

`ifdef KEYPAD_SHIFT_EN
  task automatic test_shift;
    logic [15:0] keys [5];
    int p;
    keys = '{K1, K2, K3, K4, K5};
    for (int k = 0; k < 5; k++) begin
      repeat (3) do_scan(keys[k], p);
      repeat (3) do_scan('0, p);
      if (k == 0) begin
        if (kp.digits !== {5'b10000, 5'b10000, 5'b10000, 5'b00001}) begin
          errors++; $display("FAIL shift_first: got %b", kp.digits);
        end
        checks++;
      end
    end
    if (kp.digits !== 20'b00010_00011_00100_00101) begin
      errors++; $display("FAIL shift_digits: got %b want 00010000110010000101", kp.digits);
    end
    checks++;
  endtask
`endif

  task automatic test_reset_mid;
    int p, tot;
    repeat (2) do_scan(K4, p);
    tot = 0;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); if (kp.keyValid === 1'b1) tot++; end
    rst = 1'b0;
    if (kp.keyCode !== 4'h0 || kp.keyHeld !== 1'b0) begin errors++; $display("FAIL rstmid_outs: got c%h h%b want c0 h0", kp.keyCode, kp.keyHeld); end
    checks++;
`ifdef KEYPAD_SHIFT_EN
    if (kp.digits !== ALL_BLANK) begin errors++; $display("FAIL rstmid_digits: got %b want %b", kp.digits, ALL_BLANK); end
    checks++;
`endif
    for (int s = 0; s < 3; s++) begin
      do_scan(K4, p);
      if (s < 2) tot += p;
    end
    if (tot != 0) begin errors++; $display("FAIL rstmid_nopulse: got %0d pulses want 0", tot); end
    checks++;
    if (p != 1 || kp.keyCode !== 4'h4) begin errors++; $display("FAIL rstmid_recount: got %0d pulses code %h want 1 pulse code 4", p, kp.keyCode); end
    checks++;
    repeat (3) do_scan('0, p);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_multi;
    test_release_glitch;
`ifdef KEYPAD_SHIFT_EN
    test_shift;
`endif
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad (Pmod KYPD layout), synchronizes and debounces the row returns, and reports one decoded hex code per press. This is the input-side counterpart of the multiplexed seven-segment display path: the display block drives anodes and reads nothing back, while this block drives columns and reads rows. Its optional digit buffer uses the display's 5-bit digit format, so it can feed `SevenSegFourDigwithEnable` directly and replace the switch/enter entry path.

## Interface
- `SCWIDTH`, 15, column dwell is 2^SCWIDTH clocks.
- `DBCOUNT`, 4, consecutive full scans a key state must hold to be accepted (press or release). Legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `row`  in  4  keypad row returns, active-low, asynchronous.
- `col`  out  4  column drive, active-low, one-hot-zero.
- `keyValid`  out  1  one-cycle pulse when a press is accepted.
- `keyCode`  out  4  hex code of the last accepted key; holds its value between presses.
- `keyHeld`  out  1  high while the accepted key is down or being release-debounced.
- `multiKey`  out  1  registered at each scan end; high when more than one key was seen in that scan.
- `digits`  out  20  present only with `KEYPAD_SHIFT_EN`; format `{d3,d2,d1,d0}`, 5 bits per digit.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer before any use.
- **Column drive:**
  - Column index `ci` runs 0..3.
  - `col = ~(4'b0001 << ci)`.
  - The dwell counter counts 0..2^SCWIDTH-1.
  - At terminal count: sample the synchronized rows for column `ci`, then advance `ci`, wrapping 3 to 0.
- **Scan end:** the sample of `ci`=3 completes a full scan, and the scan result is evaluated on that cycle.
- **Key priority:**
  - Lowest column wins, then lowest row.
  - `multiKey` is set if two or more row/column hits occurred in the scan.
- **Keymap (row r, col c):**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **FSM:** states IDLE, DEBOUNCE, HELD, RELEASE. Transitions happen only at scan end.
  - **IDLE:** key present -> DEBOUNCE with `cand`=code, `cnt`=1.
  - **DEBOUNCE:**
    - Same code -> `cnt`+1.
    - When `cnt` reaches DBCOUNT -> HELD. On the following cycle, `keyValid`=1 and `keyCode`=`cand`.
    - Different code -> restart with the new `cand`, `cnt`=1.
    - No key -> IDLE.
  - **HELD:**
    - No key -> RELEASE with `cnt`=1.
    - Any key, same or different -> stay in HELD. There is no auto-repeat, and a second key needs a full release.
  - **RELEASE:**
    - No key -> `cnt`+1; when `cnt` reaches DBCOUNT -> IDLE.
    - Any key -> HELD, with no new `keyValid`.
- **DBCOUNT=1 special case:**
  - A press is accepted on the first scan in which it is seen.
  - IDLE goes directly to HELD.
  - The release side behaves the same way: HELD goes directly to IDLE.
- **keyHeld:** high in HELD or RELEASE.
- **Reset mid-operation:**
  - All state returns to reset values on the next edge.
  - A pending candidate is discarded and no `keyValid` is emitted.

## Timing
- **Reset values:**
  - `col`=4'b1110, `ci`=0, dwell counter 0, state IDLE.
  - `keyValid`=0, `keyCode`=0, `keyHeld`=0, `multiKey`=0.
  - `digits`=20'b10000_10000_10000_10000 (all digits blank).
- **Full scan:** 4*2^SCWIDTH clocks.
- **Synchronizer delay:** 2 clocks. A press must settle at least 2 clocks before a column's dwell terminal count to be seen in that column's sample.
- **Press latency:** `keyValid` rises 1 clock after the scan end that completes DBCOUNT matching scans.
- **Pulse width:** `keyValid` is exactly 1 clock wide, and at most one pulse per accepted press.
- **Output registration:** `keyCode`, `keyHeld` and `multiKey` are all registered.

## Configuration
- **`KEYPAD_SHIFT_EN` defined:**
  - Adds a 20-bit digit buffer and the `digits` port.
  - On each `keyValid`: `digits <= {digits[14:0], 1'b0, keyCode}`. The new digit enters at d0 and the oldest digit is dropped from d3.
  - Blank is 5'b10000, which is the display block's blank code.
- **`KEYPAD_SHIFT_EN` undefined:** the buffer and the `digits` port are absent, and all other behaviour is identical.

## Structure
- **Package `keypad_pkg`:**
  - FSM state encoding.
  - `BLANK_DIGIT` = 5'b10000.
  - Keymap constant array indexed by `{row, col}`.
  - Width of the DBCOUNT counter.
- **Sub-module `keypad_col_driver`:** holds the dwell counter, `ci`, the `col` drive, the row synchronizer, and the per-column sample strobe plus scan-end strobe.
- **Top level:** FSM, priority encode, and the optional digit buffer.

## Test plan
Parameters for all scenarios: SCWIDTH=2, DBCOUNT=3, so one full scan is 16 clocks.
- **Reset:** assert `rst` for 2 clocks -> `col`=1110, all outputs at reset values, `digits` all blank; `col` then walks 1101, 1011, 0111 at 4-clock intervals.
- **Clean press:** press r1/c2 and hold for 6 scans -> exactly one `keyValid`, with `keyCode`=6, 1 clock after the 3rd matching scan end; `keyHeld`=1 until 3 empty scans after release.
- **Bounce:** key 5 present in 2 scans, absent in 1, then present in 3 -> a single `keyValid` with code 5, timed from the last 3 scans; a mid-bounce key 8 restarts the count.
- **Multi-key:** press keys 1 and D together -> `keyCode`=1, `multiKey`=1; after 1 is accepted, press 2 while 1 is still held -> no new `keyValid`.
- **Release glitch:** in RELEASE, the key reappears for 1 scan -> returns to HELD, no second pulse, `keyHeld` stays 1.
- **Shift buffer:** with `KEYPAD_SHIFT_EN`, press keys 1, 2, 3, 4, 5 -> `digits` = {0_0010, 0_0011, 0_0100, 0_0101}; `rst` mid-debounce -> all blank, no pulse.
